// File: rtl/vic_cache_lru_pkg.sv
// Shared types and defaults for the victim cache: line layout, default sizing,
// and width helpers.
package vic_cache_pkg;

  localparam int unsigned VIC_NUM_ENTRIES = 4;
  localparam int unsigned VIC_NUM_PORTS   = 2;
  localparam int unsigned VIC_SET_BITS    = 3;
  localparam int unsigned VIC_TAG_BITS    = 10;
  localparam int unsigned VIC_DATA_BITS   = 64;
  localparam int unsigned VIC_WB_DEPTH    = 2;

  typedef struct packed {
    logic [VIC_DATA_BITS-1:0] data;
    logic [VIC_TAG_BITS-1:0]  tag;
    logic [VIC_SET_BITS-1:0]  set;
    logic                     dirty;
  } vic_line_t;

  function automatic int unsigned vic_occ_bits(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

  function automatic int unsigned vic_line_bits(input int unsigned set_bits,
                                                input int unsigned tag_bits,
                                                input int unsigned data_bits);
    return data_bits + tag_bits + set_bits + 1;
  endfunction

endpackage

// File: rtl/vic_cache_lru_wb_fifo.sv
// Writeback queue: shift-register FIFO with up to PUSH_W pushes and one pop per
// cycle; index 0 is always the head, vacated slots are zeroed.
module vic_wb_fifo #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PUSH_W    = 2,
  parameter int unsigned LINE_BITS = 78,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned PCNT_W   = $clog2(PUSH_W + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [PCNT_W-1:0]                push_cnt_i,
  input  logic [PUSH_W-1:0][LINE_BITS-1:0] push_data_i,
  input  logic                             pop_i,
  output logic                             head_valid_o,
  output logic [LINE_BITS-1:0]             head_data_o,
  output logic [CNT_W-1:0]                 free_o
);

  logic [DEPTH-1:0][LINE_BITS-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  always_comb begin
    int unsigned base;
    int unsigned cnt;
    logic        do_pop;
    do_pop = pop_i && (cnt_q != '0);
    mem_d  = mem_q;
    if (do_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    // Pushes land behind whatever remains after this cycle's pop.
    base = 32'(cnt_q) - 32'(do_pop);
    cnt  = base;
    for (int unsigned j = 0; j < PUSH_W; j++) begin
      if ((PCNT_W'(j) < push_cnt_i) && (base + j < DEPTH)) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i == base + j) mem_d[i] = push_data_i[j];
        end
        cnt = cnt + 1;
      end
    end
    cnt_d = CNT_W'(cnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_valid_o = (cnt_q != '0);
  assign head_data_o  = mem_q[0];
  assign free_o       = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/vic_cache_lru.sv
// Fully-associative LRU victim cache with writeback queue for dirty overflow.
// Optional VIC_CACHE_STATS_EN adds saturating hit/miss lookup counters.
module vic_cache_lru
  import vic_cache_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = VIC_NUM_ENTRIES,
  parameter int unsigned NUM_PORTS   = VIC_NUM_PORTS,
  parameter int unsigned SET_BITS    = VIC_SET_BITS,
  parameter int unsigned TAG_BITS    = VIC_TAG_BITS,
  parameter int unsigned DATA_BITS   = VIC_DATA_BITS,
  parameter int unsigned WB_DEPTH    = VIC_WB_DEPTH,
  localparam int unsigned LINE_BITS  = vic_line_bits(SET_BITS, TAG_BITS, DATA_BITS),
  localparam int unsigned OCC_W      = vic_occ_bits(NUM_ENTRIES)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                insert_valid_i,
  input  logic [NUM_PORTS-1:0][LINE_BITS-1:0] insert_line_i,
  output logic                                insert_ready_o,
  input  logic [NUM_PORTS-1:0]                lookup_valid_i,
  input  logic [NUM_PORTS-1:0][SET_BITS-1:0]  lookup_set_i,
  input  logic [NUM_PORTS-1:0][TAG_BITS-1:0]  lookup_tag_i,
  output logic [NUM_PORTS-1:0]                hit_valid_o,
  output logic [NUM_PORTS-1:0][LINE_BITS-1:0] hit_line_o,
  output logic                                wb_valid_o,
  output logic [LINE_BITS-1:0]                wb_line_o,
  input  logic                                wb_ready_i,
  output logic [OCC_W-1:0]                    occupancy_o
`ifdef VIC_CACHE_STATS_EN
  ,
  output logic [31:0]                         hit_count_o,
  output logic [31:0]                         miss_count_o
`endif
);

  localparam int unsigned WORK_N = NUM_ENTRIES + NUM_PORTS;
  localparam int unsigned FREE_W = $clog2(WB_DEPTH + 1);
  localparam int unsigned PCNT_W = $clog2(NUM_PORTS + 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [TAG_BITS-1:0]  tag;
    logic [SET_BITS-1:0]  set;
    logic                 dirty;
  } line_t;

  typedef struct packed {
    logic  v;
    line_t l;
  } slot_t;

  typedef slot_t [WORK_N-1:0] slot_arr_t;

  // Remove slot k and close the gap so valid slots stay contiguous from 0.
  function automatic slot_arr_t drop(input slot_arr_t a, input int unsigned k);
    slot_arr_t r;
    r = a;
    for (int unsigned i = 0; i < WORK_N - 1; i++) begin
      if (i >= k) r[i] = a[i+1];
    end
    r[WORK_N-1] = '0;
    return r;
  endfunction

  slot_t [NUM_ENTRIES-1:0] tbl_q, tbl_d;
  logic  [NUM_PORTS-1:0]   hit_vld_q, hit_vld_d;
  line_t [NUM_PORTS-1:0]   hit_q, hit_d;
  logic  [OCC_W-1:0]       occ_q, occ_d;
  line_t [NUM_PORTS-1:0]   push_data;
  logic  [PCNT_W-1:0]      push_cnt;
  logic  [FREE_W-1:0]      wb_free;

  assign insert_ready_o = (wb_free >= FREE_W'(NUM_PORTS));

  always_comb begin
    slot_arr_t              wk;
    slot_arr_t              ovf;
    line_t                  ln;
    logic                   found;
    int unsigned            k;
    logic [NUM_ENTRIES-1:0] claimed;

    claimed   = '0;
    hit_vld_d = '0;
    hit_d     = '0;
    wk        = '0;
    ovf       = '0;
    ln        = '0;
    found     = 1'b0;
    k         = 0;

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (lookup_valid_i[p] && !found && tbl_q[i].v && !claimed[i] &&
            tbl_q[i].l.set == lookup_set_i[p] && tbl_q[i].l.tag == lookup_tag_i[p]) begin
          found        = 1'b1;
          claimed[i]   = 1'b1;
          hit_vld_d[p] = 1'b1;
          hit_d[p]     = tbl_q[i].l;
        end
      end
    end

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) wk[i] = tbl_q[i];
    for (int unsigned c = NUM_ENTRIES; c > 0; c--) begin
      if (claimed[c-1]) wk = drop(wk, c - 1);
    end

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (insert_valid_i[p] && insert_ready_o) begin
        ln    = insert_line_i[p];
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < WORK_N; i++) begin
          if (!found && wk[i].v && wk[i].l.set == ln.set && wk[i].l.tag == ln.tag) begin
            found    = 1'b1;
            k        = i;
            ln.dirty = ln.dirty | wk[i].l.dirty;
          end
        end
        if (found) wk = drop(wk, k);
        for (int unsigned i = WORK_N - 1; i > 0; i--) wk[i] = wk[i-1];
        wk[0] = {1'b1, ln};
      end
    end

    // Overflow slots beyond the table, gathered LRU-first, dirty ones only.
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (wk[WORK_N-1-j].v && wk[WORK_N-1-j].l.dirty) ovf[j] = wk[WORK_N-1-j];
    end
    for (int unsigned c = NUM_PORTS; c > 0; c--) begin
      if (!ovf[c-1].v) ovf = drop(ovf, c - 1);
    end
    push_cnt = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      push_data[j] = ovf[j].l;
      if (ovf[j].v) push_cnt = push_cnt + PCNT_W'(1);
    end

    occ_d = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      tbl_d[i] = wk[i];
      if (wk[i].v) occ_d = occ_d + OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q     <= '0;
      hit_vld_q <= '0;
      hit_q     <= '0;
      occ_q     <= '0;
    end else begin
      tbl_q     <= tbl_d;
      hit_vld_q <= hit_vld_d;
      hit_q     <= hit_d;
      occ_q     <= occ_d;
    end
  end

  assign hit_valid_o = hit_vld_q;
  assign hit_line_o  = hit_q;
  assign occupancy_o = occ_q;

  vic_wb_fifo #(
    .DEPTH     (WB_DEPTH),
    .PUSH_W    (NUM_PORTS),
    .LINE_BITS (LINE_BITS)
  ) u_wb_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_cnt_i   (push_cnt),
    .push_data_i  (push_data),
    .pop_i        (wb_ready_i),
    .head_valid_o (wb_valid_o),
    .head_data_o  (wb_line_o),
    .free_o       (wb_free)
  );

`ifdef VIC_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    int unsigned nh;
    int unsigned nm;
    logic [32:0] hs;
    logic [32:0] ms;
    nh = 0;
    nm = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (lookup_valid_i[p]) begin
        if (hit_vld_d[p]) nh = nh + 1;
        else              nm = nm + 1;
      end
    end
    hs         = {1'b0, hit_cnt_q} + 33'(nh);
    ms         = {1'b0, miss_cnt_q} + 33'(nm);
    hit_cnt_d  = hs[32] ? '1 : hs[31:0];
    miss_cnt_d = ms[32] ? '1 : ms[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

  a_insert_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((|insert_valid_i) && !insert_ready_o));

endmodule

// File: tb/tb_vic_cache_lru.sv
// Directed self-checking bench for vic_cache_lru at default sizing.
module tb_vic_cache_lru;
  import vic_cache_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ins_v, lk_v, hit_v;
  vic_line_t [1:0] ins_line, hit_line;
  logic [1:0][2:0] lk_set;
  logic [1:0][9:0] lk_tag;
  logic            ins_rdy, wb_v, wb_rdy;
  vic_line_t       wb_line;
  logic [2:0]      occ;
  int              n_vec = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  vic_cache_lru #(
    .NUM_ENTRIES (4),
    .NUM_PORTS   (2),
    .SET_BITS    (3),
    .TAG_BITS    (10),
    .DATA_BITS   (64),
    .WB_DEPTH    (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .insert_valid_i (ins_v),
    .insert_line_i  (ins_line),
    .insert_ready_o (ins_rdy),
    .lookup_valid_i (lk_v),
    .lookup_set_i   (lk_set),
    .lookup_tag_i   (lk_tag),
    .hit_valid_o    (hit_v),
    .hit_line_o     (hit_line),
    .wb_valid_o     (wb_v),
    .wb_line_o      (wb_line),
    .wb_ready_i     (wb_rdy),
    .occupancy_o    (occ)
  );

  function automatic vic_line_t mk(input logic [2:0] s, input logic [9:0] t,
                                   input logic d, input logic [63:0] data);
    vic_line_t l;
    l.data = data; l.tag = t; l.set = s; l.dirty = d;
    return l;
  endfunction

  localparam vic_line_t A  = mk(2, 10'h11, 1'b0, 64'hA0A0);
  localparam vic_line_t B  = mk(5, 10'h22, 1'b0, 64'hB0B0);
  localparam vic_line_t E1 = mk(0, 10'h01, 1'b1, 64'hE1);
  localparam vic_line_t E2 = mk(0, 10'h02, 1'b0, 64'hE2);
  localparam vic_line_t E3 = mk(0, 10'h03, 1'b0, 64'hE3);
  localparam vic_line_t E4 = mk(0, 10'h04, 1'b0, 64'hE4);
  localparam vic_line_t E5 = mk(0, 10'h05, 1'b0, 64'hE5);
  localparam vic_line_t E6 = mk(0, 10'h06, 1'b0, 64'hE6);
  localparam vic_line_t D1 = mk(3, 10'h31, 1'b1, 64'hD1);
  localparam vic_line_t D2 = mk(3, 10'h32, 1'b1, 64'hD2);
  localparam vic_line_t D3 = mk(3, 10'h33, 1'b0, 64'hD3);
  localparam vic_line_t D4 = mk(3, 10'h34, 1'b0, 64'hD4);
  localparam vic_line_t F1 = mk(4, 10'h41, 1'b0, 64'hF1);
  localparam vic_line_t F2 = mk(4, 10'h42, 1'b0, 64'hF2);
  localparam vic_line_t K  = mk(6, 10'h66, 1'b0, 64'hC6);
  localparam vic_line_t M1 = mk(7, 10'h71, 1'b1, 64'h71);
  localparam vic_line_t M2 = mk(7, 10'h72, 1'b0, 64'h72);
  localparam vic_line_t M3 = mk(7, 10'h73, 1'b0, 64'h73);
  localparam vic_line_t M4 = mk(7, 10'h74, 1'b0, 64'h74);
  localparam vic_line_t N1 = mk(1, 10'h81, 1'b0, 64'h81);
  localparam vic_line_t N2 = mk(1, 10'h82, 1'b0, 64'h82);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [1:0] v, input vic_line_t l0, input vic_line_t l1);
    ins_v = v; ins_line[0] = l0; ins_line[1] = l1;
    step();
    ins_v = '0;
  endtask

  task automatic lk(input logic [1:0] v, input vic_line_t l0, input vic_line_t l1);
    lk_v = v;
    lk_set[0] = l0.set; lk_tag[0] = l0.tag;
    lk_set[1] = l1.set; lk_tag[1] = l1.tag;
    step();
    lk_v = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ins_v = '0; lk_v = '0; wb_rdy = 1'b0;
    ins_line = '0; lk_set = '0; lk_tag = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occ); end
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid: got %b want 0", wb_v); end
    n_vec++; if (wb_line !== '0) begin n_bad++; $display("FAIL reset_wb_line: got %h want 0", wb_line); end
    n_vec++; if (ins_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_insert_ready: got %b want 1", ins_rdy); end
    n_vec++; if (hit_v !== 2'b00) begin n_bad++; $display("FAIL reset_hit_valid: got %b want 00", hit_v); end
    n_vec++; if (hit_line !== '0) begin n_bad++; $display("FAIL reset_hit_line: got %h want 0", hit_line); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_insert_lookup();
    ins(2'b11, A, B);
    n_vec++; if (occ !== 3'd2) begin n_bad++; $display("FAIL ins2_occ: got %0d want 2", occ); end
    lk(2'b01, A, A);
    n_vec++; if (hit_v !== 2'b01) begin n_bad++; $display("FAIL lookupA_hit_valid: got %b want 01", hit_v); end
    n_vec++; if (hit_line[0] !== A) begin n_bad++; $display("FAIL lookupA_hit_line: got %h want %h", hit_line[0], A); end
    n_vec++; if (occ !== 3'd1) begin n_bad++; $display("FAIL lookupA_occ: got %0d want 1", occ); end
    lk(2'b11, B, A);
    n_vec++; if (hit_v !== 2'b01) begin n_bad++; $display("FAIL lookupBA_hit_valid: got %b want 01", hit_v); end
    n_vec++; if (hit_line[0] !== B) begin n_bad++; $display("FAIL lookupBA_hit_line0: got %h want %h", hit_line[0], B); end
    n_vec++; if (hit_line[1] !== '0) begin n_bad++; $display("FAIL lookupBA_miss_line1: got %h want 0", hit_line[1]); end
    n_vec++; if (occ !== 3'd0) begin n_bad++; $display("FAIL lookupBA_occ: got %0d want 0", occ); end
  endtask

  task automatic test_overflow();
    ins(2'b11, E1, E2);
    ins(2'b11, E3, E4);
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL fill_occ: got %0d want 4", occ); end
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL fill_wb_valid: got %b want 0", wb_v); end
    ins(2'b11, E5, E6);
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL ovf_occ: got %0d want 4", occ); end
    n_vec++; if (wb_v !== 1'b1) begin n_bad++; $display("FAIL ovf_wb_valid: got %b want 1", wb_v); end
    n_vec++; if (wb_line !== E1) begin n_bad++; $display("FAIL ovf_wb_line: got %h want %h", wb_line, E1); end
    n_vec++; if (ins_rdy !== 1'b0) begin n_bad++; $display("FAIL ovf_insert_ready: got %b want 0", ins_rdy); end
    wb_rdy = 1'b1; step(); wb_rdy = 1'b0;
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL ovf_pop_wb_valid: got %b want 0", wb_v); end
    n_vec++; if (wb_line !== '0) begin n_bad++; $display("FAIL ovf_pop_wb_line: got %h want 0", wb_line); end
    n_vec++; if (ins_rdy !== 1'b1) begin n_bad++; $display("FAIL ovf_pop_insert_ready: got %b want 1", ins_rdy); end
  endtask

  task automatic test_backpressure();
    ins(2'b11, D1, D2);
    ins(2'b11, D3, D4);
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL bp_clean_drop_wb_valid: got %b want 0", wb_v); end
    ins(2'b11, F1, F2);
    n_vec++; if (ins_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_full_insert_ready: got %b want 0", ins_rdy); end
    n_vec++; if (wb_line !== D1) begin n_bad++; $display("FAIL bp_head_lru: got %h want %h", wb_line, D1); end
    step();
    n_vec++; if (wb_line !== D1) begin n_bad++; $display("FAIL bp_head_stable: got %h want %h", wb_line, D1); end
    n_vec++; if (wb_v !== 1'b1) begin n_bad++; $display("FAIL bp_wb_valid_held: got %b want 1", wb_v); end
    wb_rdy = 1'b1;
    step();
    n_vec++; if (wb_line !== D2) begin n_bad++; $display("FAIL bp_drain_second: got %h want %h", wb_line, D2); end
    n_vec++; if (ins_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_one_free_insert_ready: got %b want 0", ins_rdy); end
    step();
    wb_rdy = 1'b0;
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL bp_drained_wb_valid: got %b want 0", wb_v); end
    n_vec++; if (ins_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_drained_insert_ready: got %b want 1", ins_rdy); end
  endtask

  task automatic test_dual_lookup();
    lk(2'b11, F1, F1);
    n_vec++; if (hit_v !== 2'b01) begin n_bad++; $display("FAIL dual_hit_valid: got %b want 01", hit_v); end
    n_vec++; if (hit_line[0] !== F1) begin n_bad++; $display("FAIL dual_hit_line0: got %h want %h", hit_line[0], F1); end
    n_vec++; if (hit_line[1] !== '0) begin n_bad++; $display("FAIL dual_hit_line1: got %h want 0", hit_line[1]); end
    n_vec++; if (occ !== 3'd3) begin n_bad++; $display("FAIL dual_occ: got %0d want 3", occ); end
  endtask

  task automatic test_duplicate();
    ins(2'b01, mk(1, 10'h5, 1'b0, 64'h77), '0);
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL dup_first_occ: got %0d want 4", occ); end
    ins(2'b10, '0, mk(1, 10'h5, 1'b1, 64'h88));
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL dup_dirty_occ: got %0d want 4", occ); end
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL dup_no_evict: got %b want 0", wb_v); end
    ins(2'b01, mk(1, 10'h5, 1'b0, 64'h99), '0);
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL dup_clean_occ: got %0d want 4", occ); end
    lk(2'b01, mk(1, 10'h5, 1'b0, 64'h0), '0);
    n_vec++; if (hit_line[0] !== mk(1, 10'h5, 1'b1, 64'h99)) begin n_bad++; $display("FAIL dup_merged_line: got %h want %h", hit_line[0], mk(1, 10'h5, 1'b1, 64'h99)); end
    n_vec++; if (occ !== 3'd3) begin n_bad++; $display("FAIL dup_lookup_occ: got %0d want 3", occ); end
  endtask

  task automatic test_back_to_back();
    ins_v = 2'b01; ins_line[0] = K; ins_line[1] = '0;
    lk(2'b01, K, '0);
    ins_v = '0;
    n_vec++; if (hit_v !== 2'b00) begin n_bad++; $display("FAIL same_cycle_hit_valid: got %b want 00", hit_v); end
    n_vec++; if (occ !== 3'd4) begin n_bad++; $display("FAIL same_cycle_occ: got %0d want 4", occ); end
    lk(2'b10, '0, K);
    n_vec++; if (hit_v !== 2'b10) begin n_bad++; $display("FAIL next_cycle_hit_valid: got %b want 10", hit_v); end
    n_vec++; if (hit_line[1] !== K) begin n_bad++; $display("FAIL next_cycle_hit_line1: got %h want %h", hit_line[1], K); end
    n_vec++; if (occ !== 3'd3) begin n_bad++; $display("FAIL next_cycle_occ: got %0d want 3", occ); end
  endtask

  task automatic test_reset_mid();
    ins(2'b11, M1, M2);
    ins(2'b11, M3, M4);
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL mid_setup_wb_valid: got %b want 0", wb_v); end
    ins(2'b11, N1, N2);
    lk(2'b01, N1, '0);
    n_vec++; if (occ !== 3'd3) begin n_bad++; $display("FAIL mid_pre_occ: got %0d want 3", occ); end
    n_vec++; if (wb_line !== M1) begin n_bad++; $display("FAIL mid_pre_wb_line: got %h want %h", wb_line, M1); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (occ !== 3'd0) begin n_bad++; $display("FAIL mid_reset_occ: got %0d want 0", occ); end
    n_vec++; if (wb_v !== 1'b0) begin n_bad++; $display("FAIL mid_reset_wb_valid: got %b want 0", wb_v); end
    n_vec++; if (ins_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_reset_insert_ready: got %b want 1", ins_rdy); end
    n_vec++; if (hit_v !== 2'b00) begin n_bad++; $display("FAIL mid_reset_hit_valid: got %b want 00", hit_v); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_insert_lookup();
    test_overflow();
    test_backpressure();
    test_dual_lookup();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
